jstk2_spi_master: RTL
=====================

JSTK2_SPI_MASTER -- requirements
Module: jstk2_spi_master

Interface
REQ-001 SHALL have parameter TOTAL_DATA_BYTE, default 7, bytes per SPI transaction.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per byte.
REQ-003 SHALL have parameter CLK_DIV, default 50, i_clk cycles per SCLK half-period (>=1).
REQ-004 SHALL have parameter CS_SETUP_CYCLES, default 1500, i_clk cycles from CS_n low to first SCLK rise.
REQ-005 SHALL have parameter BYTE_GAP_CYCLES, default 1000, idle i_clk cycles between bytes, CS_n held low.
REQ-006 SHALL have parameter CS_HOLD_CYCLES, default 2500, i_clk cycles from last SCLK fall to CS_n high.
REQ-007 SHALL have parameter POLL_CYCLES, default 1000000, auto-poll period (used only under REQ-027).
REQ-008 i_clk  in  1  system clock; one clock; reset is asynchronous and active-low.
REQ-009 i_n_reset  in  1  asynchronous active-low reset.
REQ-010 i_start  in  1  one-cycle transaction request.
REQ-011 i_tx_data  in  TOTAL_DATA_BYTE*DATA_WIDTH  outgoing packet, most significant byte sent first.
REQ-012 o_busy  out  1  high from accepted start until o_done.
REQ-013 o_done  out  1  one-cycle pulse at transaction end.
REQ-014 o_cs_n, o_sclk, o_mosi  out  1 each  SPI mode-0 pins.
REQ-015 i_miso  in  1  SPI data in.
REQ-016 o_rx_data  out  DATA_WIDTH  last received byte; o_rx_data_valid  out  1  one-cycle pulse per byte (feeds byte-collector i_rx_data/i_rx_data_valid).

Function
REQ-017 FSM states SHALL be IDLE, CS_SETUP, SHIFT, BYTE_GAP, CS_HOLD; IDLE->CS_SETUP on accepted start; CS_SETUP->SHIFT after CS_SETUP_CYCLES; SHIFT->BYTE_GAP after a byte if bytes remain, else ->CS_HOLD; BYTE_GAP->SHIFT after BYTE_GAP_CYCLES; CS_HOLD->IDLE after CS_HOLD_CYCLES with o_done pulsed that cycle.
REQ-018 Start SHALL be accepted only in IDLE; i_tx_data latched on acceptance; starts while busy ignored, no queuing.
REQ-019 o_cs_n SHALL be low in all states except IDLE; o_sclk low outside SHIFT.
REQ-020 SCLK SHALL toggle every CLK_DIV cycles in SHIFT; exactly DATA_WIDTH rising edges per byte.
REQ-021 MOSI SHALL present the byte MSB on entry to CS_SETUP/BYTE_GAP and shift on each SCLK fall; i_miso SHALL be sampled on each SCLK rise, MSB first.
REQ-022 On the DATA_WIDTH-th SCLK fall, o_rx_data SHALL update and o_rx_data_valid pulse high for exactly one cycle, same cycle.
REQ-023 Byte counter SHALL count 0..TOTAL_DATA_BYTE-1 and clear on return to IDLE; no wrap within a transaction.
REQ-024 Exactly TOTAL_DATA_BYTE valid pulses SHALL occur per transaction; o_busy low in the o_done cycle's successor.

Reset
REQ-025 On i_n_reset low, asynchronously: state IDLE, o_cs_n=1, o_sclk=0, o_mosi=0, o_rx_data=0, o_rx_data_valid=0, o_busy=0, o_done=0, all counters 0.
REQ-026 Reset mid-transaction SHALL abort with no further valid or done pulses; next start begins a full new transaction.

Configuration
REQ-027 With JSTK2_AUTO_POLL_EN defined, an internal counter SHALL issue a start every POLL_CYCLES cycles while IDLE (counting restarts on each return to IDLE) and i_start remains usable; coincident i_start and auto-start yield one transaction. Without it, only i_start starts transactions and no poll counter exists.

Verification (CLK_DIV=2, CS_SETUP_CYCLES=4, BYTE_GAP_CYCLES=3, CS_HOLD_CYCLES=5)
REQ-028 i_start with i_tx_data=0x84_11_22_33_00_00_00, MISO model returns 0x01..0x07 -> MOSI bytes 0x84,0x11,0x22,0x33,0x00,0x00,0x00; o_rx_data pulses 0x01..0x07; one o_done.
REQ-029 Timing check -> CS_n low to first SCLK rise = 4+2 cycles; 8 rises/byte; 3-cycle gap; CS_n high 5 cycles after last fall.
REQ-030 i_start pulsed again mid-transaction -> ignored; total 7 valid pulses, one o_done.
REQ-031 i_n_reset low during byte 3 -> o_cs_n=1, o_sclk=0 immediately; no o_done; next i_start gives full 7-byte transaction.
REQ-032 JSTK2_AUTO_POLL_EN, POLL_CYCLES=200, i_start tied 0 -> transactions start 200 cycles after each return to IDLE; without macro none start.

Source files
------------

// File: rtl/jstk2_spi_master.sv
// SPI mode-0 master for the JSTK2 joystick: one CS_n frame of TOTAL_DATA_BYTE bytes, MSB first.
// Optional build macro JSTK2_AUTO_POLL_EN adds a self-start every POLL_CYCLES idle cycles.
module jstk2_spi_master #(
    parameter int TOTAL_DATA_BYTE = 7,
    parameter int DATA_WIDTH      = 8,
    parameter int CLK_DIV         = 50,
    parameter int CS_SETUP_CYCLES = 1500,
    parameter int BYTE_GAP_CYCLES = 1000,
    parameter int CS_HOLD_CYCLES  = 2500,
    parameter int POLL_CYCLES     = 1000000
) (
    input  logic                                  i_clk,
    input  logic                                  i_n_reset,
    input  logic                                  i_start,
    input  logic [TOTAL_DATA_BYTE*DATA_WIDTH-1:0] i_tx_data,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_cs_n,
    output logic                                  o_sclk,
    output logic                                  o_mosi,
    input  logic                                  i_miso,
    output logic [DATA_WIDTH-1:0]                 o_rx_data,
    output logic                                  o_rx_data_valid
);

    localparam int PKT_W   = TOTAL_DATA_BYTE * DATA_WIDTH;
    localparam int MAX_SG  = (CS_SETUP_CYCLES > BYTE_GAP_CYCLES) ? CS_SETUP_CYCLES : BYTE_GAP_CYCLES;
    localparam int MAX_HD  = (CS_HOLD_CYCLES > CLK_DIV) ? CS_HOLD_CYCLES : CLK_DIV;
    localparam int CNT_MAX = (MAX_SG > MAX_HD) ? MAX_SG : MAX_HD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_WIDTH + 1);
    localparam int BYTE_W  = $clog2(TOTAL_DATA_BYTE + 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        BYTE_GAP,
        CS_HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [BYTE_W-1:0]       byte_q, byte_d;
    logic [PKT_W-1:0]        tx_q, tx_d;
    logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    sclk_q, sclk_d;
    logic                    auto_start;
    logic                    start_accept;

`ifdef JSTK2_AUTO_POLL_EN
    localparam int POLL_W = $clog2(POLL_CYCLES + 1);
    logic [POLL_W-1:0] poll_q, poll_d;

    // Idle-time counter; leaving IDLE clears it so each return to IDLE restarts the period.
    assign auto_start = (state_q == IDLE) && (poll_q == POLL_W'(POLL_CYCLES - 1));

    always_comb begin
        poll_d = '0;
        if (state_q == IDLE && !auto_start) poll_d = poll_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) poll_q <= '0;
        else            poll_q <= poll_d;
    end
`else
    // No poll counter in this build; the period parameter has no effect.
    assign auto_start = 1'b0 & (POLL_CYCLES > 0);
`endif

    assign start_accept = (i_start || auto_start) && (state_q == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            tx_q       <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            tx_q       <= tx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
        end
    end

    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        tx_d       = tx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;

        unique case (state_q)
            IDLE: begin
                cnt_d  = '0;
                bit_d  = '0;
                byte_d = '0;
                sclk_d = 1'b0;
                if (start_accept) begin
                    state_d = CS_SETUP;
                    tx_d    = i_tx_data;
                end
            end
            CS_SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP_CYCLES - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], i_miso};
                    end else begin
                        // Whole packet shifts as one word, so the next byte's MSB lands on MOSI here.
                        tx_d = {tx_q[PKT_W-2:0], 1'b0};
                        if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                            bit_d      = '0;
                            rx_data_d  = rx_shift_q;
                            rx_valid_d = 1'b1;
                            if (byte_q == BYTE_W'(TOTAL_DATA_BYTE - 1)) begin
                                state_d = CS_HOLD;
                            end else begin
                                state_d = BYTE_GAP;
                                byte_d  = byte_q + 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BYTE_GAP: begin
                if (cnt_q == CNT_W'(BYTE_GAP_CYCLES - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CS_HOLD: begin
                if (cnt_q == CNT_W'(CS_HOLD_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    byte_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_cs_n          = (state_q == IDLE);
        o_busy          = (state_q != IDLE);
        o_done          = (state_q == CS_HOLD) && (cnt_q == CNT_W'(CS_HOLD_CYCLES - 1));
        o_sclk          = sclk_q;
        o_mosi          = tx_q[PKT_W-1];
        o_rx_data       = rx_data_q;
        o_rx_data_valid = rx_valid_q;
    end

endmodule
